// File: rtl/pacman_pkg.sv
// Shared types, key codes and the wall-probe helper for the Pac-Man motion logic.
package pacman_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PNEXT,
    S_PCUR,
    S_MOVE
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  // Point one sprite radius plus one step ahead of the centre in direction d.
  // X folds back across the tunnel by the tunnel span; Y is plain 10-bit arithmetic.
  function automatic logic [19:0] probe_point(
    input dir_t       d,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [9:0] size,
    input logic [9:0] step,
    input logic [9:0] xmin,
    input logic [9:0] xmax
  );
    logic signed [11:0] px;
    logic signed [11:0] off;
    logic signed [11:0] lo;
    logic signed [11:0] hi;
    logic [9:0]         py;
    off = signed'({2'b00, 10'(size + step)});
    lo  = signed'({2'b00, xmin});
    hi  = signed'({2'b00, xmax});
    px  = signed'({2'b00, x});
    py  = y;
    case (d)
      DIR_UP:    py = y - (size + step);
      DIR_DOWN:  py = y + (size + step);
      DIR_LEFT:  px = px - off;
      DIR_RIGHT: px = px + off;
      default:   ;
    endcase
    if (px < lo) begin
      px = px + (hi - lo);
    end else if (px > hi) begin
      px = px - (hi - lo);
    end
    return {px[9:0], py};
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings an asynchronous frame strobe into the Clk domain and emits a one-cycle tick
// on each rising edge, three Clk cycles after the asynchronous edge.
module frame_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic tick
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_tick;

  // Two-flop synchroniser, a delayed copy for edge compare, and a registered tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_tick <= r_sync & ~r_prev;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man position controller: latches the last direction key, probes the
// wall mask for the requested and current headings, then steps once or stops.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X   = 10'd150,
  parameter logic [9:0] START_Y   = 10'd236,
  parameter logic [9:0] SIZE      = 10'd4,
  parameter logic [9:0] STEP      = 10'd1,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter int         PROBE_LAT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       probe_wall,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [2:0] dir,
  output logic       busy,
  output logic       overrun
);

  localparam logic [1:0] LAT = 2'(PROBE_LAT);

  state_t             r_state;
  state_t             w_nextState;
  dir_t               r_nextDir;
  dir_t               r_reqDir;
  dir_t               r_dir;
  logic [1:0]         r_cnt;
  logic [9:0]         r_ballX;
  logic [9:0]         r_ballY;
  logic [9:0]         r_probeX;
  logic [9:0]         r_probeY;
  logic               r_overrun;
  logic [9:0]         w_moveX;
  logic [9:0]         w_moveY;
  logic signed [11:0] w_stepX;
  logic [19:0]        w_probeNext;
  logic [19:0]        w_probeCur;
  logic               w_tick;
  logic               w_busy;
  logic               w_sampleNow;
  logic               w_startFrame;
  logic               w_toCur;
  logic               w_takeNext;
  logic               w_curBlocked;

  frame_edge_sync u_frameSync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .tick     (w_tick)
  );

  assign w_probeNext = probe_point(r_nextDir, r_ballX, r_ballY, SIZE, STEP, X_MIN, X_MAX);
  assign w_probeCur  = probe_point(r_dir, r_ballX, r_ballY, SIZE, STEP, X_MIN, X_MAX);

  // Remember the most recent W/S/A/D press; any other code leaves the request alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_nextDir <= DIR_NONE;
    end else begin
      case (keycode)
        KEY_W:   r_nextDir <= DIR_UP;
        KEY_S:   r_nextDir <= DIR_DOWN;
        KEY_A:   r_nextDir <= DIR_LEFT;
        KEY_D:   r_nextDir <= DIR_RIGHT;
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Decode strobes the FSM and datapath share; probe_wall is only trusted once the count hits LAT.
  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_sampleNow  = (r_cnt == LAT);
    w_startFrame = (r_state == S_IDLE) && w_tick;
    w_toCur      = (r_state == S_PNEXT) && w_sampleNow &&
                   ((r_reqDir == DIR_NONE) || probe_wall);
    w_takeNext   = (r_state == S_PNEXT) && w_sampleNow &&
                   (r_reqDir != DIR_NONE) && !probe_wall;
    w_curBlocked = (r_state == S_PCUR) && (r_dir != DIR_NONE) && w_sampleNow && probe_wall;
  end

  // Next-state logic: requested heading first, fall back to current heading, else stop.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_nextState = S_PNEXT;
      end
      S_PNEXT: begin
        if (w_sampleNow) begin
          w_nextState = ((r_reqDir == DIR_NONE) || probe_wall) ? S_PCUR : S_MOVE;
        end
      end
      S_PCUR: begin
        if (r_dir == DIR_NONE) begin
          w_nextState = S_IDLE;
        end else if (w_sampleNow) begin
          w_nextState = probe_wall ? S_IDLE : S_MOVE;
        end
      end
      S_MOVE: begin
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Probe address, latency counter and the request snapshot taken as the frame starts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_probeX <= '0;
      r_probeY <= '0;
      r_reqDir <= DIR_NONE;
    end else if (w_startFrame) begin
      r_reqDir             <= r_nextDir;
      {r_probeX, r_probeY} <= w_probeNext;
      r_cnt                <= '0;
    end else if (w_toCur) begin
      r_cnt <= '0;
      if (r_dir != DIR_NONE) {r_probeX, r_probeY} <= w_probeCur;
    end else if (((r_state == S_PNEXT) || (r_state == S_PCUR)) && !w_sampleNow) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Heading: adopt the request when its path is open, drop to NONE when blocked ahead.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dir <= DIR_NONE;
    end else if (w_takeNext) begin
      r_dir <= r_reqDir;
    end else if (w_curBlocked) begin
      r_dir <= DIR_NONE;
    end
  end

  // One-step position update with the horizontal tunnel fold; signed math avoids underflow.
  always_comb begin
    w_moveX = r_ballX;
    w_moveY = r_ballY;
    w_stepX = signed'({2'b00, r_ballX});
    case (r_dir)
      DIR_UP:   w_moveY = r_ballY - STEP;
      DIR_DOWN: w_moveY = r_ballY + STEP;
      DIR_LEFT: begin
        w_stepX = signed'({2'b00, r_ballX}) - signed'({2'b00, STEP});
        w_moveX = (w_stepX < signed'({2'b00, X_MIN})) ? X_MAX : w_stepX[9:0];
      end
      DIR_RIGHT: begin
        w_stepX = signed'({2'b00, r_ballX}) + signed'({2'b00, STEP});
        w_moveX = (w_stepX > signed'({2'b00, X_MAX})) ? X_MIN : w_stepX[9:0];
      end
      default: ;
    endcase
  end

  // Position only changes in the single move cycle of a frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ballX <= START_X;
      r_ballY <= START_Y;
    end else if (r_state == S_MOVE) begin
      r_ballX <= w_moveX;
      r_ballY <= w_moveY;
    end
  end

  // Sticky flag for a frame tick that landed while an update was still running.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_overrun <= 1'b0;
    end else if (w_tick && w_busy) begin
      r_overrun <= 1'b1;
    end
  end

  assign probe_x   = r_probeX;
  assign probe_y   = r_probeY;
  assign BallX     = r_ballX;
  assign BallY     = r_ballY;
  assign Ball_size = SIZE;
  assign dir       = r_dir;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule
